// File: rtl/score_keeper.sv
// score_keeper: pong match flow, scores and ball serve control.
// Sits between the ball/collision logic and the score display.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   goal_p1    1-cycle pulse, p1 scores
//   goal_p2    1-cycle pulse, p2 scores
//   start      raw start button (async level)
//   score_p1   registered p1 score
//   score_p2   registered p2 score
//   game_over  high while the match is over
//   ball_reset high while the ball is parked at centre
//   serve      1-cycle pulse, launch the ball
//   serve_dir  1 = toward p2 (right), 0 = toward p1 (left)
module score_keeper #(
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       start,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       ball_reset,
    output logic       serve,
    output logic       serve_dir
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        PLAY,
        OVER
    } state_t;

    // ------------------------------------------------------------
    // Start button: synchroniser and rising-edge detector.
    // All three flops reset to 1 so a button held through reset
    // looks like "already pressed" and needs a release first.
    // ------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= start;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // ------------------------------------------------------------
    // Match state machine
    // ------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    p1_q;
    logic [3:0]    p1_d;
    logic [3:0]    p2_q;
    logic [3:0]    p2_d;
    logic          dir_q;
    logic          dir_d;
    logic          over_q;
    logic          over_d;
    logic          park_q;
    logic          park_d;
    logic          serve_q;
    logic          serve_d;

    logic [3:0]    p1_inc;
    logic [3:0]    p2_inc;

    assign p1_inc = p1_q + 4'd1;
    assign p2_inc = p2_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        dir_d   = dir_q;

        unique case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = PLAY;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            PLAY: begin
                if (goal_p1 && goal_p2) begin
                    // Simultaneous goals: point is replayed.
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end else if (goal_p1) begin
                    p1_d  = p1_inc;
                    dir_d = 1'b1;
                    if (p1_inc == WIN) begin
                        state_d = OVER;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (goal_p2) begin
                    p2_d  = p2_inc;
                    dir_d = 1'b0;
                    if (p2_inc == WIN) begin
                        state_d = OVER;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end

            OVER: begin
                if (edge_q) begin
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                    dir_d   = ~dir_q;
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        over_d  = (state_d == OVER);
        park_d  = (state_d != PLAY);
        serve_d = (state_d == PLAY) && (state_q != PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p1_q    <= 4'd0;
            p2_q    <= 4'd0;
            dir_q   <= 1'b0;
            over_q  <= 1'b0;
            park_q  <= 1'b1;
            serve_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            dir_q   <= dir_d;
            over_q  <= over_d;
            park_q  <= park_d;
            serve_q <= serve_d;
        end
    end

    assign score_p1   = p1_q;
    assign score_p2   = p2_q;
    assign game_over  = over_q;
    assign ball_reset = park_q;
    assign serve      = serve_q;
    assign serve_dir  = dir_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Game-flow controller that sits directly upstream of the seven-segment score display in the pong design. It consumes goal events from the ball/collision logic and a start button, and runs the match state machine. It produces the registered 4-bit per-player scores the display multiplexes, and it parks and serves the ball between points. It also declares game over when a player reaches WIN_SCORE.

Parameters:
WIN_SCORE, 9, points needed to win; 1..15; the display blinks at this value.
HOLD_CYCLES, 1024, cycles the ball stays parked before each serve; must be >= 1.

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
goal_p1  input  1  one-cycle pulse: ball left the p2 side, so p1 scores
goal_p2  input  1  one-cycle pulse: ball left the p1 side, so p2 scores
start  input  1  raw start button, asynchronous, level
score_p1  output  4  registered p1 score
score_p2  output  4  registered p2 score
game_over  output  1  high while in OVER
ball_reset  output  1  high: ball must be held at centre
serve  output  1  one-cycle pulse: launch the ball
serve_dir  output  1  launch direction; 1 = toward p2 (right), 0 = toward p1 (left)

Behaviour:
- Start input path:
  - 2-flop synchroniser, then a rising-edge detector (start_edge).
  - Edge is visible 3 clk after a clean 0->1 transition on start.
  - The edge detector's previous-value flop resets to 1, so a button held through reset produces no edge until it is released and pressed again.
- Reset: state=IDLE; score_p1=score_p2=0; game_over=0; ball_reset=1; serve=0; serve_dir=0; hold counter=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, HOLD, PLAY, OVER.
- IDLE:
  - ball_reset=1; goals ignored.
  - start_edge -> HOLD, with hold counter loaded to HOLD_CYCLES-1.
- HOLD:
  - ball_reset=1; the counter decrements each cycle.
  - When the counter==0, next state is PLAY. HOLD lasts exactly HOLD_CYCLES cycles.
  - Goals and start_edge are ignored.
- PLAY:
  - serve=1 only in the first PLAY cycle; ball_reset=0 for all of PLAY.
  - goal_p1 alone: score_p1+1; serve_dir<=1.
  - goal_p2 alone: score_p2+1; serve_dir<=0.
  - The serve always goes toward the player who conceded the point.
  - If the incremented score == WIN_SCORE -> OVER; else -> HOLD (counter reloaded).
  - goal_p1 and goal_p2 in the same cycle: no score change; serve_dir unchanged; -> HOLD (point replayed).
  - A goal coincident with the serve cycle is processed normally.
  - start_edge is ignored.
- OVER:
  - game_over=1; ball_reset=1; scores frozen at the final value, so one score equals WIN_SCORE.
  - Goals are ignored.
  - start_edge: clear both scores; serve_dir<=~serve_dir; game_over<=0 on the same edge; -> HOLD.
- Scores never exceed WIN_SCORE. The increment occurs only in PLAY, which is left as soon as WIN_SCORE is reached.
- Hold counter width is $clog2(HOLD_CYCLES+1).
- Reset mid-operation (any state, including mid-HOLD or while serve=1) returns every register to its reset values on that edge. There is no partial clear.

Test Plan:
- HOLD_CYCLES=4: reset, pulse start -> start_edge 3 cycles later; ball_reset stays 1 for 4 further cycles, then serve=1 for exactly 1 cycle with ball_reset=0; scores stay 0/0.
- In PLAY, pulse goal_p1 -> score_p1=1 next cycle, serve_dir=1, ball_reset=1 for 4 cycles, one serve pulse. Then goal_p2 -> score_p2=1, serve_dir=0.
- goal_p1 and goal_p2 high in the same PLAY cycle -> scores unchanged, serve_dir unchanged, HOLD re-entered, one serve pulse after 4 cycles.
- Drive p1 to 8, then goal_p1 -> score_p1=9, game_over=1, ball_reset=1. Further goals leave 9/x unchanged. start -> scores 0/0, game_over=0, serve_dir toggled, serve after hold.
- Goals during IDLE, HOLD and OVER, and start pulses during PLAY/HOLD -> no state, score or serve change.
- Assert reset mid-HOLD with start held high -> all reset values next cycle; no game starts until start is released and re-pressed.
